operand_latch_stage: RTL

OPERAND_LATCH_STAGE -- requirements
Module: operand_latch_stage

---
 rtl/operand_latch_stage.sv | 108 ++++++++++
 1 files changed

// File: rtl/operand_latch_stage.sv
// p2->p3 operand latch: picks forwarded or register-file operands and inserts one bubble per load-use hazard.
// Latency 1 cycle (2 for a load-use instruction); stall holds p1/p2 for the single bubble cycle.
module operand_latch_stage #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] read_addr_A,
  input  logic [ADDR_W-1:0] read_addr_B,
  input  logic [ADDR_W-1:0] write_addr_p2,
  input  logic [1:0]        op1_p2,
  input  logic [3:0]        op3_p2,
  input  logic [DATA_W-1:0] rf_data_A,
  input  logic [DATA_W-1:0] rf_data_B,
  input  logic [DATA_W-1:0] fwd_data_A,
  input  logic [DATA_W-1:0] fwd_data_B,
  input  logic              fwd_en_A,
  input  logic              fwd_en_B,
  input  logic              valid_p3,
  input  logic [1:0]        op1_p3,
  input  logic [ADDR_W-1:0] write_addr_p3,
  input  logic              flush,
  output logic              out_valid,
  output logic [DATA_W-1:0] operand_A,
  output logic [DATA_W-1:0] operand_B,
  output logic [ADDR_W-1:0] write_addr_p3_out,
  output logic [1:0]        op1_p3_out,
  output logic [3:0]        op3_p3_out,
  output logic              stall,
  output logic [15:0]       stall_count
);

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } state_t;

  localparam logic [1:0]  OP1_LOAD = 2'b00;
  localparam logic [15:0] CNT_MAX  = 16'hFFFF;

  state_t            state_q;
  state_t            state_d;
  logic              load_hazard;
  logic              capture;
  logic              out_valid_d;
  logic              cnt_inc;
  logic [DATA_W-1:0] sel_A;
  logic [DATA_W-1:0] sel_B;
  logic [15:0]       stall_cnt_q;

  assign sel_A = fwd_en_A ? fwd_data_A : rf_data_A;
  assign sel_B = fwd_en_B ? fwd_data_B : rf_data_B;

  assign load_hazard = valid_p3 && (op1_p3 == OP1_LOAD) && in_valid &&
                       ((write_addr_p3 == read_addr_A) || (write_addr_p3 == read_addr_B));

  // Priority: reset, then flush, then hazard (only checked in RUN), then normal capture.
  always_comb begin
    state_d     = RUN;
    stall       = 1'b0;
    capture     = 1'b0;
    out_valid_d = 1'b0;
    cnt_inc     = 1'b0;
    if (reset || flush) begin
      state_d = RUN;
    end else if ((state_q == RUN) && load_hazard) begin
      stall   = 1'b1;
      cnt_inc = 1'b1;
      state_d = BUBBLE;
    end else begin
      capture     = 1'b1;
      out_valid_d = in_valid;
      state_d     = RUN;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q           <= RUN;
      out_valid         <= 1'b0;
      operand_A         <= '0;
      operand_B         <= '0;
      write_addr_p3_out <= '0;
      op1_p3_out        <= '0;
      op3_p3_out        <= '0;
      stall_cnt_q       <= '0;
    end else begin
      state_q   <= state_d;
      out_valid <= out_valid_d;
      // Data fields only move on a capture so a bubble leaves the previous contents in place.
      if (capture) begin
        operand_A         <= sel_A;
        operand_B         <= sel_B;
        write_addr_p3_out <= write_addr_p2;
        op1_p3_out        <= op1_p2;
        op3_p3_out        <= op3_p2;
      end
      if (cnt_inc && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign stall_count = stall_cnt_q;

endmodule
